// File: rtl/axi2ahb_wctrl.sv
// Purpose : write-address sequencer of the AXI-to-AHB bridge; turns one AW command
//           into a string of AHB address phases paced by the W-beat handshake.
// Latency : AWREADY high 1 cycle after reset release; first NONSEQ no earlier than
//           2 cycles after AW accept; then 1 beat/cycle with W valid and HREADY high.
// Backpressure: HREADY=0 freezes every AHB address output; a missing W beat shows as
//           BUSY (mid-burst) or IDLE (before a NONSEQ); AWVALID is ignored mid-burst.
//
// Ports:
//   ACLK, ARESETN                   clock, asynchronous active-low reset
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST AXI write command, AWVALID/AWREADY handshake
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST AHB address phase, HREADY from the slave
//   cmd_id                           ID of the active or most recent command
//   ctrl_wdata_valid/_last           W beat present (and whether it carries WLAST)
//   ctrl_wdata_ready                 address phase for the held beat accepted now
//   ctrl_err                         one-cycle pulse: illegal command or WLAST mismatch

module axi2ahb_wctrl #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  // AXI write-address channel
  input  logic [AXI_ID_WIDTH-1:0]   AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  // AHB address phase
  output logic [AXI_ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  input  logic                      HREADY,
  // write-data block interface
  output logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic                      ctrl_wdata_valid,
  input  logic                      ctrl_wdata_last,
  output logic                      ctrl_wdata_ready,
  output logic                      ctrl_err
);

  localparam int         MAX_SIZE   = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t                    r_state,   n_state;
  logic                      r_awready, n_awready;
  htrans_t                   r_htrans,  n_htrans;
  logic [AXI_ADDR_WIDTH-1:0] r_haddr,   n_haddr;
  logic [2:0]                r_hsize,   n_hsize;
  logic [AXI_ID_WIDTH-1:0]   r_cmd_id,  n_cmd_id;
  logic [7:0]                r_cnt,     n_cnt;      // beats left after the current one
  logic                      r_first,   n_first;    // next phase is the burst's first
  logic                      r_restart, n_restart;  // next phase restarts after a 1KB cross
  logic                      r_fixed,   n_fixed;
  logic                      r_wrap,    n_wrap;
  logic [AXI_ADDR_WIDTH-1:0] r_wmask,   n_wmask;    // wrap-length minus 1 (WRAP only)
  logic                      r_err,     n_err;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic                      w_cmd_acc;
  logic                      w_size_bad;
  logic                      w_burst_bad;
  logic                      w_cmd_bad;
  logic                      w_wrap_len_ok;
  logic [AXI_ADDR_WIDTH-1:0] w_wrap_bytes;
  logic [AXI_ADDR_WIDTH-1:0] w_cmd_mask;

  assign w_cmd_acc     = (r_state == ST_IDLE) && r_awready && AWVALID;
  assign w_size_bad    = (AWSIZE > MAX_SIZE_L);
  assign w_burst_bad   = (AWBURST == 2'b11);
  assign w_cmd_bad     = w_size_bad || w_burst_bad;
  assign w_wrap_len_ok = (AWLEN == 8'd1) || (AWLEN == 8'd3) ||
                         (AWLEN == 8'd7) || (AWLEN == 8'd15);
  assign w_wrap_bytes  = (AXI_ADDR_WIDTH'(AWLEN) + AXI_ADDR_WIDTH'(1)) << AWSIZE;
  assign w_cmd_mask    = w_wrap_bytes - AXI_ADDR_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Beat acceptance and next-address arithmetic
  // ---------------------------------------------------------------------------
  logic                      w_beat_acc;
  logic                      w_last_beat;
  logic [AXI_ADDR_WIDTH-1:0] w_step;
  logic [AXI_ADDR_WIDTH-1:0] w_incr_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_wrap_addr;
  logic [AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic                      w_cross;

  assign w_beat_acc  = ((r_htrans == HT_NONSEQ) || (r_htrans == HT_SEQ)) && HREADY;
  assign w_last_beat = (r_cnt == 8'd0);
  assign w_step      = AXI_ADDR_WIDTH'(1) << r_hsize;
  assign w_incr_addr = r_haddr + w_step;
  // WRAP: low bits roll over inside the aligned window, upper bits stay put.
  assign w_wrap_addr = (r_haddr & ~r_wmask) | (w_incr_addr & r_wmask);
  assign w_next_addr = r_fixed ? r_haddr : (r_wrap ? w_wrap_addr : w_incr_addr);
  // An INCR step landing on a 1KB-aligned address has crossed into a new 1KB page,
  // which an undefined-length AHB burst may not do without restarting with NONSEQ.
  assign w_cross     = !r_fixed && !r_wrap && (w_incr_addr[9:0] == 10'd0);

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    n_state   = r_state;
    n_awready = r_awready;
    n_htrans  = r_htrans;
    n_haddr   = r_haddr;
    n_hsize   = r_hsize;
    n_cmd_id  = r_cmd_id;
    n_cnt     = r_cnt;
    n_first   = r_first;
    n_restart = r_restart;
    n_fixed   = r_fixed;
    n_wrap    = r_wrap;
    n_wmask   = r_wmask;
    n_err     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        n_awready = 1'b1;
        n_htrans  = HT_IDLE;
        if (w_cmd_acc) begin
          n_state   = ST_BURST;
          n_awready = 1'b0;
          n_cmd_id  = AWID;
          n_haddr   = AWADDR;
          n_cnt     = AWLEN;
          n_first   = 1'b1;
          n_restart = 1'b0;
          // Illegal commands fall back to INCR with the widest legal beat.
          n_hsize   = w_size_bad ? MAX_SIZE_L : AWSIZE;
          n_fixed   = !w_cmd_bad && (AWBURST == 2'b00);
          // A WRAP of unsupported length degrades to INCR addressing.
          n_wrap    = !w_cmd_bad && (AWBURST == 2'b10) && w_wrap_len_ok;
          n_wmask   = w_cmd_mask;
          n_err     = w_cmd_bad;
        end
      end

      ST_BURST: begin
        n_awready = 1'b0;
        if (w_beat_acc) begin
          n_haddr   = w_next_addr;
          n_first   = 1'b0;
          n_restart = w_cross;
          // WLAST is only checked, never trusted: the counter owns the flow.
          n_err     = (ctrl_wdata_last != w_last_beat);
          if (w_last_beat) begin
            n_state   = ST_IDLE;
            n_awready = 1'b1;
          end else begin
            n_cnt = r_cnt - 8'd1;
          end
        end
        // Address-phase outputs only move when the slave is ready.
        if (HREADY) begin
          if (w_beat_acc && w_last_beat) begin
            n_htrans = HT_IDLE;
          end else if (ctrl_wdata_valid) begin
            n_htrans = (n_first || n_restart) ? HT_NONSEQ : HT_SEQ;
          end else begin
            // BUSY is only legal inside a burst; before a (re)start use IDLE.
            n_htrans = (n_first || n_restart) ? HT_IDLE : HT_BUSY;
          end
        end
      end

      default: begin
        n_state   = ST_IDLE;
        n_awready = 1'b0;
        n_htrans  = HT_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= ST_IDLE;
      r_awready <= 1'b0;
      r_htrans  <= HT_IDLE;
      r_haddr   <= '0;
      r_hsize   <= 3'd0;
      r_cmd_id  <= '0;
      r_cnt     <= 8'd0;
      r_first   <= 1'b0;
      r_restart <= 1'b0;
      r_fixed   <= 1'b0;
      r_wrap    <= 1'b0;
      r_wmask   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= n_state;
      r_awready <= n_awready;
      r_htrans  <= n_htrans;
      r_haddr   <= n_haddr;
      r_hsize   <= n_hsize;
      r_cmd_id  <= n_cmd_id;
      r_cnt     <= n_cnt;
      r_first   <= n_first;
      r_restart <= n_restart;
      r_fixed   <= n_fixed;
      r_wrap    <= n_wrap;
      r_wmask   <= n_wmask;
      r_err     <= n_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign AWREADY          = r_awready;
  assign HADDR            = r_haddr;
  assign HTRANS           = r_htrans;
  assign HWRITE           = (r_htrans != HT_IDLE);
  assign HSIZE            = r_hsize;
  assign HBURST           = 3'b001;  // always undefined-length INCR on AHB
  assign cmd_id           = r_cmd_id;
  assign ctrl_wdata_ready = w_beat_acc;
  assign ctrl_err         = r_err;

endmodule

// File: tb/tb_axi2ahb_wctrl.sv
module tb_axi2ahb_wctrl;

  localparam int IDW   = 1;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MAXSZ = $clog2(DW / 8);

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  logic           ACLK = 1'b0;
  logic           ARESETN;
  logic [IDW-1:0] AWID;
  logic [AW-1:0]  AWADDR;
  logic [7:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;
  logic [AW-1:0]  HADDR;
  logic [1:0]     HTRANS;
  logic           HWRITE;
  logic [2:0]     HSIZE;
  logic [2:0]     HBURST;
  logic           HREADY;
  logic [IDW-1:0] cmd_id;
  logic           ctrl_wdata_valid;
  logic           ctrl_wdata_last;
  logic           ctrl_wdata_ready;
  logic           ctrl_err;

  always #5 ACLK = ~ACLK;

  axi2ahb_wctrl #(
    .AXI_ID_WIDTH  (IDW),
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW)
  ) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .AWID            (AWID),
    .AWADDR          (AWADDR),
    .AWLEN           (AWLEN),
    .AWSIZE          (AWSIZE),
    .AWBURST         (AWBURST),
    .AWVALID         (AWVALID),
    .AWREADY         (AWREADY),
    .HADDR           (HADDR),
    .HTRANS          (HTRANS),
    .HWRITE          (HWRITE),
    .HSIZE           (HSIZE),
    .HBURST          (HBURST),
    .HREADY          (HREADY),
    .cmd_id          (cmd_id),
    .ctrl_wdata_valid(ctrl_wdata_valid),
    .ctrl_wdata_last (ctrl_wdata_last),
    .ctrl_wdata_ready(ctrl_wdata_ready),
    .ctrl_err        (ctrl_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: the whole burst is precomputed as a list of beat addresses,
  // each tagged with whether that beat must open with NONSEQ.
  logic [31:0]    q_addr[$];
  bit             q_ns[$];
  int             m_len, m_idx, m_cyc;
  bit             m_active, m_exp_err, m_chk_id, p_final, p_hready, p_valid;
  logic [1:0]     m_exp_ht;
  logic [2:0]     m_size;
  logic [IDW-1:0] m_id;
  bit             aw_pend;
  int             mode, bad_idx, gap_cnt, stall_cnt, busy_cnt;

  task automatic build_model(input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit          bad;
    int          sz;
    logic [1:0]  b;
    logic [31:0] bytes, wl, base, a;
    bad   = (size > 3'(MAXSZ)) || (burst == 2'b11);
    sz    = (size > 3'(MAXSZ)) ? MAXSZ : int'(size);
    b     = bad ? 2'b01 : burst;
    bytes = 32'd1 << sz;
    q_addr.delete();
    q_ns.delete();
    for (int i = 0; i <= len; i++) begin
      case (b)
        2'b00:   a = addr;
        2'b10: begin
          wl   = 32'(len + 1) * bytes;
          base = addr - (addr % wl);
          a    = base + ((addr - base) + 32'(i) * bytes) % wl;
        end
        default: a = addr + 32'(i) * bytes;
      endcase
      q_addr.push_back(a);
      q_ns.push_back((i == 0) || (b == 2'b01 && a[9:0] == 10'd0));
    end
    m_size    = 3'(sz);
    m_len     = len;
    m_idx     = 0;
    m_cyc     = 0;
    m_active  = 1'b1;
    m_exp_err = bad;
    m_chk_id  = 1'b1;
    m_id      = AWID;
  endtask

  // One clock: drive just after the rising edge, check on the falling edge.
  task automatic step();
    logic rdy_exp;
    @(posedge ACLK);
    #1;
    AWVALID = aw_pend;
    case (mode)
      0: begin
        HREADY           = 1'b1;
        ctrl_wdata_valid = 1'b1;
      end
      1: begin
        HREADY           = ($urandom % 5) != 0;
        ctrl_wdata_valid = ($urandom % 4) != 0;
      end
      default: begin
        ctrl_wdata_valid = !(m_active && m_idx >= 2 && gap_cnt < 3);
        if (!ctrl_wdata_valid) gap_cnt++;
        HREADY = !(m_active && m_idx == 2 && HTRANS == T_SEQ && stall_cnt < 2);
        if (!HREADY) stall_cnt++;
      end
    endcase
    ctrl_wdata_last = m_active && ((m_idx == m_len) != (m_idx == bad_idx));

    @(negedge ACLK);
    check_val("ctrl_err", ctrl_err, m_exp_err);
    m_exp_err = 1'b0;
    if (m_chk_id) begin
      check_val("cmd_id", cmd_id, m_id);
      m_chk_id = 1'b0;
    end
    if (m_active) begin
      m_cyc++;
      if (m_cyc == 1)
        m_exp_ht = T_IDLE;
      else if (p_hready)
        m_exp_ht = p_valid ? (q_ns[m_idx] ? T_NONSEQ : T_SEQ)
                           : (q_ns[m_idx] ? T_IDLE : T_BUSY);
      check_val("awready_burst", AWREADY, 1'b0);
      check_val("htrans", HTRANS, m_exp_ht);
      check_val("haddr", HADDR, q_addr[m_idx]);
      if (HTRANS == T_BUSY) busy_cnt++;
      rdy_exp = m_exp_ht[1] && HREADY;
      check_val("wdata_ready", ctrl_wdata_ready, rdy_exp);
      if (rdy_exp) begin
        check_val("hsize", HSIZE, m_size);
        check_val("hwrite", HWRITE, 1'b1);
        check_val("hburst", HBURST, 3'b001);
        m_exp_err = (ctrl_wdata_last != (m_idx == m_len));
        m_idx++;
        if (m_idx > m_len) begin
          m_active = 1'b0;
          p_final  = 1'b1;
        end
      end
    end else begin
      check_val("ready_idle", ctrl_wdata_ready, 1'b0);
      if (p_final) begin
        check_val("awready_end", AWREADY, 1'b1);
        check_val("htrans_end", HTRANS, T_IDLE);
        check_val("hwrite_end", HWRITE, 1'b0);
        p_final = 1'b0;
      end
    end
    if (AWVALID && AWREADY) begin
      aw_pend = 1'b0;
      build_model(AWADDR, int'(AWLEN), AWSIZE, AWBURST);
    end
    p_hready = HREADY;
    p_valid  = ctrl_wdata_valid;
  endtask

  task automatic run_cmd(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int md, input int bad, input int abort_at);
    int n;
    mode      = md;
    bad_idx   = bad;
    gap_cnt   = 0;
    stall_cnt = 0;
    busy_cnt  = 0;
    AWID      = id;
    AWADDR    = addr;
    AWLEN     = 8'(len);
    AWSIZE    = size;
    AWBURST   = burst;
    aw_pend   = 1'b1;
    n = 0;
    while (!m_active && n < 50) begin
      step();
      n++;
    end
    check_val("aw_handshake", m_active, 1'b1);
    n = 0;
    while (m_active && m_idx != abort_at && n < 3000) begin
      step();
      n++;
    end
    if (abort_at < 0) begin
      check_val("burst_complete", m_active, 1'b0);
      step();
    end else begin
      check_val("abort_point", m_idx, abort_at);
    end
  endtask

  task automatic do_reset();
    @(posedge ACLK);
    #3;
    ARESETN = 1'b0;
    #1;
    check_val("rst_awready", AWREADY, 1'b0);
    check_val("rst_htrans", HTRANS, T_IDLE);
    check_val("rst_haddr", HADDR, 32'h0);
    check_val("rst_hwrite", HWRITE, 1'b0);
    check_val("rst_hsize", HSIZE, 3'd0);
    check_val("rst_cmd_id", cmd_id, 1'b0);
    check_val("rst_ready", ctrl_wdata_ready, 1'b0);
    check_val("rst_err", ctrl_err, 1'b0);
    aw_pend          = 1'b0;
    AWVALID          = 1'b0;
    ctrl_wdata_valid = 1'b0;
    ctrl_wdata_last  = 1'b0;
    HREADY           = 1'b1;
    m_active         = 1'b0;
    m_exp_err        = 1'b0;
    m_chk_id         = 1'b0;
    p_final          = 1'b0;
    p_hready         = 1'b1;
    p_valid          = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    ARESETN = 1'b1;
    mode    = 0;
    step();
    check_val("awready_after_reset", AWREADY, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  r_sz;
    logic [1:0]  r_bt;
    int          r_len, pick;
    logic [31:0] r_addr;

    ARESETN          = 1'b0;
    AWID             = '0;
    AWADDR           = '0;
    AWLEN            = '0;
    AWSIZE           = '0;
    AWBURST          = '0;
    AWVALID          = 1'b0;
    HREADY           = 1'b1;
    ctrl_wdata_valid = 1'b0;
    ctrl_wdata_last  = 1'b0;
    aw_pend          = 1'b0;
    mode             = 0;
    bad_idx          = -1;
    do_reset();

    // INCR full speed, WRAP, 1KB crossing, FIXED
    run_cmd(1'b0, 32'h100, 3, 3'd2, 2'b01, 0, -1, -1);
    run_cmd(1'b1, 32'h38,  3, 3'd2, 2'b10, 0, -1, -1);
    run_cmd(1'b0, 32'h3F8, 3, 3'd2, 2'b01, 0, -1, -1);
    run_cmd(1'b1, 32'h44,  2, 3'd1, 2'b00, 0, -1, -1);

    // W gap plus HREADY stall in the middle of the burst
    run_cmd(1'b0, 32'h500, 3, 3'd2, 2'b01, 2, -1, -1);
    check_val("busy_seen", busy_cnt > 0, 1'b1);
    check_val("stall_cycles", stall_cnt, 2);

    // WLAST mismatch, reserved burst type, oversize beat
    run_cmd(1'b0, 32'h80,  1, 3'd2, 2'b01, 0, 0, -1);
    run_cmd(1'b1, 32'h200, 3, 3'd2, 2'b11, 0, -1, -1);
    run_cmd(1'b0, 32'h40,  2, 3'd5, 2'b10, 1, -1, -1);

    // Randomised commands with random W/HREADY pacing
    for (int k = 0; k < 40; k++) begin
      r_sz = 3'($urandom_range(0, MAXSZ));
      r_bt = 2'($urandom % 3);
      if (r_bt == 2'b10) begin
        pick  = $urandom % 4;
        r_len = (2 << pick) - 1;
      end else begin
        r_len = $urandom_range(0, 20);
      end
      if (($urandom % 2) == 0)
        r_addr = (32'($urandom_range(1, 60)) << 10) - (32'($urandom_range(1, 6)) << r_sz);
      else
        r_addr = ($urandom & 32'hFFF0) & ~((32'd1 << r_sz) - 32'd1);
      if (($urandom % 8) == 0) r_bt = 2'b11;
      if (($urandom % 10) == 0) r_sz = 3'($urandom_range(3, 7));
      run_cmd(1'($urandom), r_addr, r_len, r_sz, r_bt, ($urandom % 3 == 0) ? 0 : 1, -1, -1);
    end

    // Reset in the middle of an 8-beat burst, then a clean command
    run_cmd(1'b0, 32'h1000, 7, 3'd2, 2'b01, 0, -1, 2);
    do_reset();
    run_cmd(1'b1, 32'h2000, 3, 3'd2, 2'b01, 0, -1, -1);
    check_val("cmd_id_after_reset", cmd_id, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi2ahb_wctrl.md
Name: axi2ahb_wctrl

Overview:
Write-address sequencer for the AXI-to-AHB bridge. Accepts one AXI write-address command at a time and expands it into AHB address phases (HADDR/HTRANS/HSIZE/HBURST). Each address phase is paced by the write-data block's beat handshake (ctrl_wdata_valid/ready/last). Supplies the command ID that the data block returns on BID.

Parameters:
AXI_ID_WIDTH, 1, width of AWID and cmd_id
AXI_ADDR_WIDTH, 32, width of AWADDR and HADDR
AXI_DATA_WIDTH, 32, data bus width; sets the maximum legal AWSIZE (log2(AXI_DATA_WIDTH/8))

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
AWID  in  AXI_ID_WIDTH  write command ID
AWADDR  in  AXI_ADDR_WIDTH  start address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  bytes per beat, log2
AWBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP
AWVALID  in  1  command valid
AWREADY  out  1  command accepted
HADDR  out  AXI_ADDR_WIDTH  AHB address
HTRANS  out  2  AHB transfer type
HWRITE  out  1  constant 1 while HTRANS != IDLE, else 0
HSIZE  out  3  equals the latched AWSIZE
HBURST  out  3  fixed at 3'b001 (INCR)
HREADY  in  1  AHB ready
cmd_id  out  AXI_ID_WIDTH  ID of the active or most recent command
ctrl_wdata_valid  in  1  data block holds a W beat
ctrl_wdata_last  in  1  that beat carries WLAST
ctrl_wdata_ready  out  1  address phase for the beat accepted this cycle
ctrl_err  out  1  one-cycle pulse on a WLAST/beat-count mismatch

Behaviour:
- Reset:
  - Outputs: AWREADY=0, HTRANS=IDLE(00), HADDR=0, HSIZE=0, HWRITE=0, cmd_id=0, ctrl_wdata_ready=0, ctrl_err=0.
  - State=IDLE. Beat counter=0.
  - AWREADY rises on the first ACLK edge after reset release.
- State machine:
  - IDLE:
    - AWREADY=1 (registered), HTRANS=IDLE.
    - On AWVALID&&AWREADY: latch AWID into cmd_id, plus AWADDR, AWLEN, AWSIZE, AWBURST. Set the beat counter to AWLEN, set first=1, go to BURST. AWREADY drops the next cycle.
  - BURST:
    - If ctrl_wdata_valid=1: HTRANS = NONSEQ when first=1 or a 1KB-boundary restart is flagged, otherwise SEQ.
    - If ctrl_wdata_valid=0: HTRANS = IDLE when first=1 (or a restart is flagged), otherwise BUSY(01).
    - Address phase accepted = HTRANS in {NONSEQ,SEQ} && HREADY.
    - ctrl_wdata_ready = that condition, combinational from registered HTRANS and HREADY.
    - On acceptance: advance HADDR, decrement the counter, clear first.
    - When the counter was 0 at acceptance: go to IDLE. HTRANS=IDLE next cycle; AWREADY=1 next cycle.
  - All AHB address outputs are held while HREADY=0.
- Address arithmetic (next = current address):
  - FIXED: HADDR unchanged every beat.
  - INCR: HADDR += (1<<AWSIZE).
  - WRAP: wrap length = (AWLEN+1)<<AWSIZE. Bits below log2(wrap length) increment modulo the wrap length; upper bits are held.
  - Legal AXI WRAP lengths only: 2, 4, 8 or 16 beats.
- HBURST is always INCR, so bursts are undefined-length AHB.
- 1KB boundary: if the next INCR address crosses a 1KB boundary (bits [9:0] wrap to 0), the next transfer is NONSEQ. This restart is the only case other than first=1 that yields NONSEQ.
- Last check: on acceptance, compare ctrl_wdata_last with (counter==0). On a mismatch, ctrl_err=1 for one cycle. Sequencing still follows the counter; ctrl_wdata_last does not change flow.
- Simultaneous events: AWVALID is ignored in BURST. An IDLE-to-BURST transition and the first NONSEQ never share a cycle; there is a minimum 1-cycle gap.
- Illegal commands: AWSIZE > log2(AXI_DATA_WIDTH/8), or AWBURST=11. The command is accepted and treated as INCR with size clamped to the maximum; ctrl_err pulses at command acceptance.
- Reset mid-burst: everything returns to reset values immediately (asynchronous). No partial burst is resumed.
- Throughput: 1 beat per cycle when ctrl_wdata_valid and HREADY are held high.

Test Plan:
1. INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, valid and HREADY held 1 -> HADDR 0x100,0x104,0x108,0x10C; HTRANS NONSEQ,SEQ,SEQ,SEQ; 4 ctrl_wdata_ready pulses; AWREADY=1 the cycle after the last beat.
2. WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> HADDR 0x38,0x3C,0x30,0x34.
3. INCR, AWADDR=0x3F8, AWLEN=3, AWSIZE=2 -> 0x3F8 SEQ-chain, then 0x400 issued as NONSEQ, then 0x404 SEQ.
4. ctrl_wdata_valid drops after beat 1 for 3 cycles, and HREADY=0 for 2 cycles during beat 2 -> HTRANS=BUSY during the gap with HADDR held; HADDR/HTRANS stable while HREADY=0; beat count still 4.
5. AWLEN=1 but ctrl_wdata_last=1 on beat 0 -> ctrl_err pulse on beat 0; two beats still issued. AWBURST=11 -> ctrl_err at acceptance and INCR addressing.
6. ARESETN asserted during beat 2 of 8 -> HTRANS=IDLE and AWREADY=0 immediately; after release, a new AWID=1 command runs cleanly with cmd_id=1.
